idu_is_pipe1_div_sched: RTL

Issue-stage scheduler for the pipe1 issue slot, which is shared by ALU and DIV ops.
- Buffers dispatched divide ops in an in-order FIFO.
- Tracks divider occupancy so only one divide is in flight at a time.
- Arbitrates pipe1 each cycle between the ALU requester and the FIFO head, with a starvation guard.
- Drives the issue-side inputs of the RF pipe1 stage (idu_idu_rf_pipe1_*).

---
 rtl/idu_is_pipe1_div_sched_if.sv | 42 ++++
 rtl/idu_is_pipe1_div_sched.sv | 114 +++++++++++
 2 files changed

// File: rtl/idu_is_pipe1_div_sched_if.sv
// Pipe1 issue-slot signal bundle: divide dispatch, ALU arbitration, divider status and RF-stage issue fields.
// The master drives the scheduler's inputs and the slave is the scheduler itself.
interface idu_is_pipe1_div_sched_if #(
    parameter int PTR_W = 2
);
    logic             rtu_global_flush;
    logic             dp_div_vld;
    logic             dp_div_rdy;
    logic [4:0]       dp_div_iid;
    logic [2:0]       dp_div_funct3;
    logic [5:0]       dp_div_psrc1;
    logic [5:0]       dp_div_psrc2;
    logic [5:0]       dp_div_pdst;
    logic             alu_req_vld;
    logic             alu_gnt;
    logic             exu_idu_div_done;
    logic             idu_idu_rf_pipe1_vld;
    logic             idu_is_pipe1_sel_div;
    logic [4:0]       idu_is_div_iid;
    logic [2:0]       idu_is_div_funct3;
    logic [5:0]       idu_is_div_psrc1;
    logic [5:0]       idu_is_div_psrc2;
    logic [5:0]       idu_is_div_pdst;
    logic             idu_is_div_busy;
    logic [PTR_W:0]   idu_is_div_cnt;

    modport master (
        output rtu_global_flush, dp_div_vld, dp_div_iid, dp_div_funct3,
               dp_div_psrc1, dp_div_psrc2, dp_div_pdst, alu_req_vld, exu_idu_div_done,
        input  dp_div_rdy, alu_gnt, idu_idu_rf_pipe1_vld, idu_is_pipe1_sel_div,
               idu_is_div_iid, idu_is_div_funct3, idu_is_div_psrc1, idu_is_div_psrc2,
               idu_is_div_pdst, idu_is_div_busy, idu_is_div_cnt
    );

    modport slave (
        input  rtu_global_flush, dp_div_vld, dp_div_iid, dp_div_funct3,
               dp_div_psrc1, dp_div_psrc2, dp_div_pdst, alu_req_vld, exu_idu_div_done,
        output dp_div_rdy, alu_gnt, idu_idu_rf_pipe1_vld, idu_is_pipe1_sel_div,
               idu_is_div_iid, idu_is_div_funct3, idu_is_div_psrc1, idu_is_div_psrc2,
               idu_is_div_pdst, idu_is_div_busy, idu_is_div_cnt
    );
endinterface

// File: rtl/idu_is_pipe1_div_sched.sv
// Pipe1 issue scheduler: in-order divide FIFO, single-divide occupancy tracking,
// and same-cycle ALU/DIV arbitration with a starvation guard for the waiting divide.
module idu_is_pipe1_div_sched #(
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                       clk,
    input  logic                       rst_clk,
    idu_is_pipe1_div_sched_if.slave    bus
);
    localparam int                SC_W     = $clog2(STARVE_LIM + 1);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [SC_W-1:0]   SC_MAX   = SC_W'(STARVE_LIM);

    typedef struct packed {
        logic [4:0] iid;
        logic [2:0] funct3;
        logic [5:0] psrc1;
        logic [5:0] psrc2;
        logic [5:0] pdst;
    } div_op_t;

    div_op_t           fifo_mem [DEPTH];
    div_op_t           head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    cnt;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_nxt;
    logic              busy;
    logic              fifo_empty;
    logic              push;
    logic              div_cand;
    logic              div_issue;
    logic              alu_win;
    logic              rdy;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v == SC_MAX) ? v : v + 1'b1;
    endfunction

    // Arbitration: a waiting divide only beats a requesting ALU once the ALU has won STARVE_LIM times.
    always_comb begin
        fifo_empty = (cnt == '0);
        rdy        = (cnt < CNT_FULL) & ~bus.rtu_global_flush;
        push       = bus.dp_div_vld & rdy;
        div_cand   = ~fifo_empty & ~busy & ~bus.rtu_global_flush;
        div_issue  = div_cand & (~bus.alu_req_vld | (starve_cnt == SC_MAX));
        alu_win    = bus.alu_req_vld & ~div_issue & ~bus.rtu_global_flush;
        head       = fifo_empty ? '0 : fifo_mem[rd_ptr];
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (div_issue || fifo_empty) begin
            starve_nxt = '0;
        end else if (div_cand && alu_win) begin
            starve_nxt = sat_inc(starve_cnt);
        end
    end

    // Control state: pointers, occupancy, starvation count and divider busy flag.
    always_ff @(posedge clk) begin
        if (rst_clk || bus.rtu_global_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            starve_cnt <= '0;
            busy       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (div_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, div_issue})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            starve_cnt <= starve_nxt;
            if (div_issue) begin
                busy <= 1'b1;
            end else if (busy && bus.exu_idu_div_done) begin
                busy <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; emptiness is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{iid:    bus.dp_div_iid,
                                  funct3: bus.dp_div_funct3,
                                  psrc1:  bus.dp_div_psrc1,
                                  psrc2:  bus.dp_div_psrc2,
                                  pdst:   bus.dp_div_pdst};
        end
    end

    assign bus.dp_div_rdy           = rdy;
    assign bus.alu_gnt              = alu_win;
    assign bus.idu_idu_rf_pipe1_vld = div_issue | alu_win;
    assign bus.idu_is_pipe1_sel_div = div_issue;
    assign bus.idu_is_div_iid       = head.iid;
    assign bus.idu_is_div_funct3    = head.funct3;
    assign bus.idu_is_div_psrc1     = head.psrc1;
    assign bus.idu_is_div_psrc2     = head.psrc2;
    assign bus.idu_is_div_pdst      = head.pdst;
    assign bus.idu_is_div_busy      = busy;
    assign bus.idu_is_div_cnt       = cnt;
endmodule
